// File: rtl/mult_sequencer.sv
// Two-requester round-robin front end to a 16x16 unsigned shift-add multiplier
// that fetches both operands from memory and writes the 32-bit product back.
module mult_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*ADDR_W-1:0] req_raddr1,
  input  logic [2*ADDR_W-1:0] req_raddr2,
  input  logic [2*ADDR_W-1:0] req_waddr,
  output logic [1:0]          done,
  output logic [31:0]         result,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_raddr1,
  output logic [ADDR_W-1:0]   mem_raddr2,
  input  logic [15:0]         mem_rdata1,
  input  logic [15:0]         mem_rdata2,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [31:0]         mem_wdata,
  output logic [2:0]          dbg_state
);

  // Handshake: a command on requester i is taken at a PCLK rising edge where
  // req_valid[i] & req_ready[i]; ready is only offered in IDLE to one requester.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    MUL   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        prio;    // 1 = requester 1 wins a tie
  logic        owner;
  logic [3:0]  cnt;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [1:0]  grant;
  logic        accept;

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
    req_ready = (state == IDLE) ? grant : 2'b00;
    accept    = |(req_valid & req_ready);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = MUL;
      MUL:     if (cnt == 4'd15) state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prio       <= 1'b0;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      mcand      <= 32'd0;
      mplier     <= 16'd0;
      acc        <= 32'd0;
      result     <= 32'd0;
      mem_raddr1 <= '0;
      mem_raddr2 <= '0;
      mem_waddr  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          // The address registers double as the latched command.
          owner      <= grant[1];
          prio       <= ~grant[1];
          mem_raddr1 <= grant[1] ? req_raddr1[2*ADDR_W-1:ADDR_W] : req_raddr1[ADDR_W-1:0];
          mem_raddr2 <= grant[1] ? req_raddr2[2*ADDR_W-1:ADDR_W] : req_raddr2[ADDR_W-1:0];
          mem_waddr  <= grant[1] ? req_waddr[2*ADDR_W-1:ADDR_W]  : req_waddr[ADDR_W-1:0];
        end
        LOAD: begin
          mcand  <= {16'd0, mem_rdata1};
          mplier <= mem_rdata2;
          acc    <= 32'd0;
          cnt    <= 4'd0;
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        WRITE: result <= acc;
        default: ;
      endcase
    end
  end

  assign mem_we    = (state == WRITE);
  assign mem_wdata = acc;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: memory model with one-cycle read latency,
// per-scenario tasks with hand-computed expectations.
module tb_mult_sequencer;
  localparam int AW = 32;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*AW-1:0] req_raddr1, req_raddr2, req_waddr;
  logic [1:0]    done;
  logic [31:0]   result;
  logic          busy;
  logic [AW-1:0] mem_raddr1, mem_raddr2;
  logic [15:0]   mem_rdata1, mem_rdata2;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [2:0]    dbg_state;

  logic [15:0] mem [0:255];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  mult_sequencer #(.ADDR_W(AW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_raddr1(req_raddr1), .req_raddr2(req_raddr2), .req_waddr(req_waddr),
    .done(done), .result(result), .busy(busy),
    .mem_raddr1(mem_raddr1), .mem_raddr2(mem_raddr2),
    .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .dbg_state(dbg_state)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  always @(posedge PCLK) begin
    mem_rdata1 <= mem[mem_raddr1[7:0]];
    mem_rdata2 <= mem[mem_raddr2[7:0]];
  end

  task automatic set_req(input int idx, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] wa);
    req_raddr1[idx*AW +: AW] = a1;
    req_raddr2[idx*AW +: AW] = a2;
    req_waddr[idx*AW +: AW]  = wa;
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  // t = edge number at which the handshake completes, -1 on timeout.
  task automatic wait_accept(output int t, output logic [1:0] g);
    t = -1;
    g = 2'b00;
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((req_valid & req_ready) != 2'b00) begin
        t = cyc + 1;
        g = req_valid & req_ready;
        return;
      end
      @(negedge PCLK);
      #1;
    end
  endtask

  // Observes cycles t .. t+19 (the cycle starting at edge k has cyc == k).
  task automatic monitor(input int t, output int t_we, output int t_done, output int n_we,
                         output int n_done, output logic [31:0] wd, output logic [31:0] wa,
                         output logic [31:0] ra1, output logic [1:0] dn);
    t_we = -1; t_done = -1; n_we = 0; n_done = 0;
    wd = '0; wa = '0; ra1 = '0; dn = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      #1;
      if (cyc == t) ra1 = mem_raddr1;
      if (mem_we) begin n_we++; t_we = cyc; wd = mem_wdata; wa = mem_waddr; end
      if (done != 2'b00) begin n_done++; t_done = cyc; dn = done; end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    req_valid = 2'b11;
    #2;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_ready: got %b exp 01", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b exp 00", done); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rst_result: got %h exp 0", result); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b exp 0", mem_we); end
    n_checks++; if (mem_raddr1 !== '0 || mem_raddr2 !== '0) begin n_fail++; $display("FAIL rst_raddr: got %h/%h exp 0", mem_raddr1, mem_raddr2); end
    n_checks++; if (mem_waddr !== '0 || mem_wdata !== '0) begin n_fail++; $display("FAIL rst_wport: got %h/%h exp 0", mem_waddr, mem_wdata); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    req_valid = 2'b00;
  endtask

  task automatic test_basic();
    int t, t_we, t_done, n_we, n_done;
    logic [1:0] g, dn;
    logic [31:0] wd, wa, ra1;
    do_reset();
    set_req(0, 32'd1, 32'd2, 32'h10);
    req_valid = 2'b01;
    wait_accept(t, g);
    @(posedge PCLK); #1; req_valid = 2'b00;
    monitor(t, t_we, t_done, n_we, n_done, wd, wa, ra1, dn);
    n_checks++; if (g !== 2'b01) begin n_fail++; $display("FAIL basic_grant: got %b exp 01", g); end
    n_checks++; if (ra1 !== 32'd1) begin n_fail++; $display("FAIL basic_fetch_addr: got %h exp 1", ra1); end
    n_checks++; if (n_we != 1) begin n_fail++; $display("FAIL basic_we_count: got %0d exp 1", n_we); end
    n_checks++; if (t_we != t + 18) begin n_fail++; $display("FAIL basic_we_time: got %0d exp %0d", t_we, t + 18); end
    n_checks++; if (wa !== 32'h10) begin n_fail++; $display("FAIL basic_waddr: got %h exp 10", wa); end
    n_checks++; if (wd !== 32'h0000000F) begin n_fail++; $display("FAIL basic_wdata: got %h exp 0000000f", wd); end
    n_checks++; if (n_done != 1 || dn !== 2'b01) begin n_fail++; $display("FAIL basic_done: got %0d x %b exp 1 x 01", n_done, dn); end
    n_checks++; if (t_done != t + 19) begin n_fail++; $display("FAIL basic_done_time: got %0d exp %0d", t_done, t + 19); end
    n_checks++; if (result !== 32'd15) begin n_fail++; $display("FAIL basic_result: got %0d exp 15", result); end
  endtask

  task automatic test_max();
    int t, t_we, t_done, n_we, n_done;
    logic [1:0] g, dn;
    logic [31:0] wd, wa, ra1;
    set_req(1, 32'd3, 32'd4, 32'h20);
    req_valid = 2'b10;
    wait_accept(t, g);
    @(posedge PCLK); #1; req_valid = 2'b00;
    monitor(t, t_we, t_done, n_we, n_done, wd, wa, ra1, dn);
    n_checks++; if (g !== 2'b10) begin n_fail++; $display("FAIL max_grant: got %b exp 10", g); end
    n_checks++; if (wd !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_wdata: got %h exp fffe0001", wd); end
    n_checks++; if (wa !== 32'h20) begin n_fail++; $display("FAIL max_waddr: got %h exp 20", wa); end
    n_checks++; if (n_done != 1 || dn !== 2'b10) begin n_fail++; $display("FAIL max_done: got %0d x %b exp 1 x 10", n_done, dn); end
    n_checks++; if (result !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_result: got %h exp fffe0001", result); end
  endtask

  task automatic test_zero();
    int t, t_we, t_done, n_we, n_done;
    logic [1:0] g, dn;
    logic [31:0] wd, wa, ra1;
    set_req(0, 32'd5, 32'd6, 32'h30);
    req_valid = 2'b01;
    wait_accept(t, g);
    @(posedge PCLK); #1; req_valid = 2'b00;
    monitor(t, t_we, t_done, n_we, n_done, wd, wa, ra1, dn);
    n_checks++; if (t_we != t + 18 || wd !== 32'd0) begin n_fail++; $display("FAIL zero_write: got t=%0d d=%h exp t=%0d d=0", t_we, wd, t + 18); end
    n_checks++; if (t_done != t + 19) begin n_fail++; $display("FAIL zero_done_time: got %0d exp %0d", t_done, t + 19); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL zero_result: got %h exp 0", result); end
  endtask

  task automatic test_drop_valid();
    int t, t_we, t_done, n_we, n_done;
    logic [1:0] g, dn;
    logic [31:0] wd, wa, ra1;
    set_req(0, 32'd9, 32'd10, 32'h40);
    req_valid = 2'b01;
    wait_accept(t, g);
    @(posedge PCLK); #1;
    set_req(0, 32'd11, 32'd12, 32'h50);
    req_valid = 2'b00;
    monitor(t, t_we, t_done, n_we, n_done, wd, wa, ra1, dn);
    n_checks++; if (ra1 !== 32'd9) begin n_fail++; $display("FAIL drop_fetch_addr: got %h exp 9", ra1); end
    n_checks++; if (wa !== 32'h40) begin n_fail++; $display("FAIL drop_waddr: got %h exp 40", wa); end
    n_checks++; if (wd !== 32'd54) begin n_fail++; $display("FAIL drop_wdata: got %0d exp 54", wd); end
    n_checks++; if (t_done != t + 19 || dn !== 2'b01) begin n_fail++; $display("FAIL drop_done: got t=%0d %b exp t=%0d 01", t_done, dn, t + 19); end
  endtask

  task automatic test_back_to_back();
    int t, t_prev, t_we, t_done, n_we, n_done;
    logic [1:0] g, dn, exp_g;
    logic [31:0] wd, wa, ra1, exp_r;
    set_req(0, 32'd1, 32'd2, 32'h70);
    set_req(1, 32'd3, 32'd4, 32'h74);
    req_valid = 2'b11;
    do_reset();
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_r = (k % 2 == 1) ? 32'hFFFE0001 : 32'd15;
      wait_accept(t, g);
      monitor(t, t_we, t_done, n_we, n_done, wd, wa, ra1, dn);
      n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL b2b_grant%0d: got %b exp %b", k, g, exp_g); end
      if (k > 0) begin
        n_checks++; if (t != t_prev + 21) begin n_fail++; $display("FAIL b2b_accept_time%0d: got %0d exp %0d", k, t, t_prev + 21); end
      end
      n_checks++; if (result !== exp_r || dn !== exp_g) begin n_fail++; $display("FAIL b2b_result%0d: got %h %b exp %h %b", k, result, dn, exp_r, exp_g); end
      t_prev = t;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_abort();
    int t, t_we, t_done, n_we, n_done;
    logic [1:0] g, dn;
    logic [31:0] wd, wa, ra1;
    @(negedge PCLK);
    set_req(0, 32'd1, 32'd2, 32'h60);
    req_valid = 2'b01;
    wait_accept(t, g);
    @(posedge PCLK); #1; req_valid = 2'b00;
    for (int i = 0; i < 30 && cyc != t + 10; i++) @(negedge PCLK);
    n_checks++; if (busy !== 1'b1 || dbg_state !== 3'd3) begin n_fail++; $display("FAIL abort_in_mul: got busy=%b st=%0d exp 1/3", busy, dbg_state); end
    PRESETn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", busy); end
    n_checks++; if (mem_we !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL abort_we_done: got %b %b exp 0 00", mem_we, done); end
    n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL abort_result: got %h exp 0", result); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    set_req(0, 32'd7, 32'd8, 32'h64);
    req_valid = 2'b01;
    wait_accept(t, g);
    @(posedge PCLK); #1; req_valid = 2'b00;
    monitor(t, t_we, t_done, n_we, n_done, wd, wa, ra1, dn);
    n_checks++; if (n_we != 1 || wd !== 32'd14 || wa !== 32'h64) begin n_fail++; $display("FAIL abort_next_write: got n=%0d d=%0d a=%h exp 1/14/64", n_we, wd, wa); end
    n_checks++; if (n_done != 1 || t_done != t + 19) begin n_fail++; $display("FAIL abort_next_done: got n=%0d t=%0d exp 1/%0d", n_done, t_done, t + 19); end
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL abort_next_result: got %0d exp 14", result); end
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid = 2'b00;
    req_raddr1 = '0; req_raddr2 = '0; req_waddr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    mem[1] = 16'd3;      mem[2] = 16'd5;
    mem[3] = 16'hFFFF;   mem[4] = 16'hFFFF;
    mem[5] = 16'd0;      mem[6] = 16'h1234;
    mem[7] = 16'd2;      mem[8] = 16'd7;
    mem[9] = 16'd6;      mem[10] = 16'd9;
    mem[11] = 16'd100;   mem[12] = 16'd200;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_drop_valid();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
